// File: rtl/pci_uart_tx_gate.sv
// pci_uart_tx_gate: settles per-channel PCI/UART ready conditions and grants one channel at a time, round-robin
module pci_uart_tx_gate #(
    parameter int NUM_CH        = 4,
    parameter int STATE_W       = 3,
    parameter int LOAD_W        = 6,
    parameter int IDLE_STATE    = 0,
    parameter int LOAD_THRESH   = 0,
    parameter int SETTLE_CYCLES = 2,
    parameter int TIMEOUT       = 64,
    localparam int CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_CH*STATE_W-1:0] state,
    input  logic [NUM_CH*LOAD_W-1:0]  workload,
    input  logic [NUM_CH-1:0]         req,
    input  logic [NUM_CH-1:0]         done,
    output logic [NUM_CH-1:0]         enable,
    output logic [CH_W-1:0]           grant_id,
    output logic                      active,
    output logic                      timeout_err
);
    localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);
    localparam int TMR_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {S_IDLE, S_GRANT, S_GAP} fsm_t;

    fsm_t              fsm_q, fsm_d;
    logic [CNT_W-1:0]  cnt_q [NUM_CH];
    logic [CNT_W-1:0]  cnt_d [NUM_CH];
    logic [NUM_CH-1:0] qual, eligible, enable_q, enable_d;
    logic [CH_W-1:0]   grant_id_q, grant_id_d, last_q, last_d, sel;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic              active_q, active_d, timeout_err_q, timeout_err_d;
    logic              hit_done, hit_abort, hit_timeout, rel;

    // Qualify each channel and advance its settle counter; the granted or just-released channel is held at zero
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            qual[i] = req[i] && state[i*STATE_W +: STATE_W] == STATE_W'(IDLE_STATE)
                      && workload[i*LOAD_W +: LOAD_W] <= LOAD_W'(LOAD_THRESH);
            cnt_d[i] = (!qual[i] || (fsm_q != S_IDLE && grant_id_q == CH_W'(i))) ? '0
                     : (cnt_q[i] == CNT_W'(SETTLE_CYCLES)) ? cnt_q[i] : cnt_q[i] + 1'b1;
            eligible[i] = cnt_q[i] == CNT_W'(SETTLE_CYCLES);
        end
    end

    // First eligible channel above the previous winner, wrapping; smallest distance is assigned last and wins
    always_comb begin
        sel = last_q;
        for (int k = NUM_CH; k >= 1; k--) begin
            if (eligible[(int'(last_q) + k) % NUM_CH]) sel = CH_W'((int'(last_q) + k) % NUM_CH);
        end
    end

    assign hit_done    = done[grant_id_q];
    assign hit_abort   = !req[grant_id_q];
    assign hit_timeout = TIMEOUT != 0 && timer_q == TMR_W'(TIMEOUT - 1);
    assign rel         = hit_done || hit_abort || hit_timeout;

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) fsm_q <= S_IDLE;
        else fsm_q <= fsm_d;
    end

    // Next state: arbitrate in IDLE, hold until release, then one mandatory gap cycle
    always_comb begin
        fsm_d = fsm_q;
        case (fsm_q)
            S_IDLE:  fsm_d = |eligible ? S_GRANT : S_IDLE;
            S_GRANT: fsm_d = rel ? S_GAP : S_GRANT;
            default: fsm_d = S_IDLE;
        endcase
    end

    // Outputs and grant bookkeeping; done outranks abort, which outranks timeout, so only a pure timeout flags an error
    always_comb begin
        enable_d      = '0;
        active_d      = 1'b0;
        timeout_err_d = 1'b0;
        grant_id_d    = grant_id_q;
        last_d        = last_q;
        timer_d       = timer_q;
        case (fsm_q)
            S_IDLE: begin
                if (|eligible) begin
                    enable_d   = NUM_CH'(1) << sel;
                    active_d   = 1'b1;
                    grant_id_d = sel;
                    last_d     = sel;
                    timer_d    = '0;
                end
            end
            S_GRANT: begin
                enable_d      = rel ? '0 : enable_q;
                active_d      = !rel;
                timeout_err_d = hit_timeout && !hit_done && !hit_abort;
                timer_d       = (rel || TIMEOUT == 0) ? timer_q : timer_q + 1'b1;
            end
            default: ;
        endcase
    end

    // Datapath registers; last resets to the top channel so channel 0 is searched first
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            enable_q      <= '0;
            grant_id_q    <= '0;
            active_q      <= 1'b0;
            timeout_err_q <= 1'b0;
            timer_q       <= '0;
            last_q        <= CH_W'(NUM_CH - 1);
            for (int i = 0; i < NUM_CH; i++) cnt_q[i] <= '0;
        end else begin
            enable_q      <= enable_d;
            grant_id_q    <= grant_id_d;
            active_q      <= active_d;
            timeout_err_q <= timeout_err_d;
            timer_q       <= timer_d;
            last_q        <= last_d;
            for (int i = 0; i < NUM_CH; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    assign enable      = enable_q;
    assign grant_id    = grant_id_q;
    assign active      = active_q;
    assign timeout_err = timeout_err_q;
endmodule
